param_timer_gen: RTL and testbench



---
 rtl/timer_pkg.sv | 45 ++++
 rtl/timer_ring.sv | 38 +++
 rtl/param_timer_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_param_timer_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the parametrised phase / time-pulse generator.
//   - FSM state constants (RUN, HALT, STEP) and the state type
//   - helpers that turn the generator parameters into counter widths and
//     strobe positions
//   - a legality check evaluated at elaboration by param_timer_gen
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef logic [1:0] timer_state_t;

    localparam timer_state_t ST_RUN  = 2'd0;
    localparam timer_state_t ST_HALT = 2'd1;
    localparam timer_state_t ST_STEP = 2'd2;

    // Width of the position counter covering DIV*NPHASE clocks.
    function automatic int pos_width(input int div, input int nphase);
        return (div * nphase > 1) ? $clog2(div * nphase) : 1;
    endfunction

    // Width of the time-pulse index covering NT pulses.
    function automatic int tp_width(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

    // Position at which the overflow strobe fires: OVF_DLY clocks after
    // the CT phase ends.
    function automatic int ovf_pos(input int div, input int ct_ph, input int ovf_dly);
        return div * (ct_ph + 1) + ovf_dly - 1;
    endfunction

    // The strobe must land before the end of the time pulse, so CT cannot be
    // the last phase and the delay cannot run past the final phase.
    function automatic bit params_legal(input int div, input int nphase, input int nt,
                                        input int rt_ph, input int wt_ph,
                                        input int ct_ph, input int ovf_dly);
        return (div >= 1) && (nphase >= 3) && (nt >= 2) &&
               (rt_ph >= 0) && (rt_ph < nphase) &&
               (wt_ph >= 0) && (wt_ph < nphase) &&
               (ct_ph >= 0) && (ct_ph < nphase - 1) &&
               (ovf_dly >= 1) && (ovf_dly <= div * (nphase - 1 - ct_ph));
    endfunction

endpackage

// File: rtl/timer_ring.sv
// ---------------------------------------------------------------------------
// timer_ring
// One-hot ring register. Priority: reset, clear, load, advance.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset (ring -> all zero)
//   clear    - blank the ring (all zero)
//   load     - load load_val (used to restart at a given position)
//   load_val - one-hot value to load
//   advance  - rotate the hot bit one place towards the MSB, wrapping
//   ring     - current ring contents
// ---------------------------------------------------------------------------
module timer_ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] ring
);

    // Ring state; a blank ring stays blank until reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ring <= '0;
        end else if (clear) begin
            ring <= '0;
        end else if (load) begin
            ring <= load_val;
        end else if (advance) begin
            ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
        end
    end

endmodule

// File: rtl/param_timer_gen.sv
// ---------------------------------------------------------------------------
// param_timer_gen
// Phase / time-pulse generator at the root of the timing chain. CLOCK is
// divided into NPHASE phases of DIV clocks; NT time pulses form one memory
// cycle. All outputs are registered and describe the counter state loaded
// on the same edge.
// Ports:
//   CLOCK, SIM_RST  - clock and synchronous active-low reset
//   VCC, GND        - power pins, functionally unused
//   STOP            - halt request, acted on only at a time-pulse boundary
//   STEP            - single-step request (only with TIMER_STEP_EN)
//   PHS / PHS_n     - one-hot phase and its inverse
//   RT, WT, CT      - phase strobes; CT_n, WT_n their inverses
//   T               - one-hot time pulse
//   MCT_END         - last clock of the memory cycle
//   OVFSTB_n        - active-low overflow strobe, once per time pulse
//   HALTED          - high while stopped
// Optional feature macro: TIMER_STEP_EN (single-step state). When it is not
// defined the STEP input is ignored and the STEP state does not exist.
// ---------------------------------------------------------------------------
module param_timer_gen
    import timer_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int NPHASE  = 4,
    parameter int NT      = 12,
    parameter int RT_PH   = 0,
    parameter int WT_PH   = 1,
    parameter int CT_PH   = 2,
    parameter int OVF_DLY = 1
) (
    input  logic              CLOCK,
    input  logic              SIM_RST,
    input  logic              VCC,
    input  logic              GND,
    input  logic              STOP,
    input  logic              STEP,
    output logic [NPHASE-1:0] PHS,
    output logic [NPHASE-1:0] PHS_n,
    output logic              RT,
    output logic              WT,
    output logic              CT,
    output logic              CT_n,
    output logic              WT_n,
    output logic [NT-1:0]     T,
    output logic              MCT_END,
    output logic              OVFSTB_n,
    output logic              HALTED
);

    localparam int NPOS  = DIV * NPHASE;
    localparam int POS_W = pos_width(DIV, NPHASE);
    localparam int TP_W  = tp_width(NT);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);
    localparam logic [POS_W-1:0] POS_OVF  = POS_W'(ovf_pos(DIV, CT_PH, OVF_DLY));
    localparam logic [TP_W-1:0]  TP_LAST  = TP_W'(NT - 1);

    if (!params_legal(DIV, NPHASE, NT, RT_PH, WT_PH, CT_PH, OVF_DLY)) begin : g_bad_params
        $error("param_timer_gen: illegal parameter combination");
    end

    // Per-position decode tables built at elaboration, so the phase of a
    // position never needs a runtime divide.
    function automatic logic [NPOS-1:0] phase_mask(input int ph);
        logic [NPOS-1:0] m;
        m = '0;
        for (int i = 0; i < NPOS; i++) begin
            if ((i / DIV) == ph) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NPOS-1:0] start_mask();
        logic [NPOS-1:0] m;
        m = '0;
        for (int i = 0; i < NPOS; i++) begin
            if ((i % DIV) == 0) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NPOS-1:0] RT_MASK    = phase_mask(RT_PH);
    localparam logic [NPOS-1:0] WT_MASK    = phase_mask(WT_PH);
    localparam logic [NPOS-1:0] CT_MASK    = phase_mask(CT_PH);
    localparam logic [NPOS-1:0] START_MASK = start_mask();

    timer_state_t     st, st_n;
    logic [POS_W-1:0] pos, pos_n;
    logic [TP_W-1:0]  tp, tp_n, tp_inc;
    logic             live, live_n;
    logic             at_end;
    logic             unused_pwr;

    assign unused_pwr = VCC ^ GND;

`ifndef TIMER_STEP_EN
    logic unused_step;
    assign unused_step = STEP;
`endif

    assign at_end = (pos == POS_LAST);
    assign tp_inc = (tp == TP_LAST) ? '0 : tp + 1'b1;

    // Next-state logic. 'live' says whether the outputs show the counters;
    // it drops on reset and on halting, and the first edge after either
    // shows position 0 without advancing.
    always_comb begin
        st_n   = st;
        pos_n  = pos;
        tp_n   = tp;
        live_n = live;
        case (st)
            ST_RUN: begin
                if (!live) begin
                    live_n = 1'b1;
                end else if (at_end) begin
                    pos_n = '0;
                    tp_n  = tp_inc;
                    if (STOP) begin
                        st_n   = ST_HALT;
                        live_n = 1'b0;
                    end
                end else begin
                    pos_n = pos + 1'b1;
                end
            end
            ST_HALT: begin
                if (!STOP) begin
                    st_n = ST_RUN;
`ifdef TIMER_STEP_EN
                end else if (STEP) begin
                    st_n   = ST_STEP;
                    live_n = 1'b1;
`endif
                end
            end
`ifdef TIMER_STEP_EN
            ST_STEP: begin
                if (at_end) begin
                    pos_n = '0;
                    tp_n  = tp_inc;
                    if (!STOP) begin
                        st_n = ST_RUN;
                    end else if (!STEP) begin
                        st_n   = ST_HALT;
                        live_n = 1'b0;
                    end
                end else begin
                    pos_n = pos + 1'b1;
                end
            end
`endif
            default: begin
                st_n   = ST_RUN;
                live_n = 1'b0;
            end
        endcase
    end

    // Counters, FSM and the scalar output strobes, all decoded from the
    // next state so they line up with the counters on the same edge.
    always_ff @(posedge CLOCK) begin
        if (!SIM_RST) begin
            st       <= ST_RUN;
            pos      <= '0;
            tp       <= '0;
            live     <= 1'b0;
            RT       <= 1'b0;
            WT       <= 1'b0;
            CT       <= 1'b0;
            MCT_END  <= 1'b0;
            OVFSTB_n <= 1'b1;
            HALTED   <= 1'b0;
        end else begin
            st       <= st_n;
            pos      <= pos_n;
            tp       <= tp_n;
            live     <= live_n;
            RT       <= live_n & RT_MASK[pos_n];
            WT       <= live_n & WT_MASK[pos_n];
            CT       <= live_n & CT_MASK[pos_n];
            MCT_END  <= live_n && (tp_n == TP_LAST) && (pos_n == POS_LAST);
            OVFSTB_n <= !(live_n && (pos_n == POS_OVF));
            HALTED   <= (st_n == ST_HALT);
        end
    end

    // Both rings blank when the outputs go dark and restart from the held
    // counters when they come back; otherwise they simply rotate.
    logic phs_adv, t_adv, ring_load;

    assign ring_load = live_n & ~live;
    assign phs_adv   = live & live_n & START_MASK[pos_n];
    assign t_adv     = live & live_n & at_end;

    timer_ring #(.WIDTH(NPHASE)) u_phs_ring (
        .clk      (CLOCK),
        .rst_n    (SIM_RST),
        .clear    (~live_n),
        .load     (ring_load),
        .load_val (NPHASE'(1)),
        .advance  (phs_adv),
        .ring     (PHS)
    );

    timer_ring #(.WIDTH(NT)) u_t_ring (
        .clk      (CLOCK),
        .rst_n    (SIM_RST),
        .clear    (~live_n),
        .load     (ring_load),
        .load_val (NT'(1) << tp_n),
        .advance  (t_adv),
        .ring     (T)
    );

    assign PHS_n = ~PHS;
    assign CT_n  = ~CT;
    assign WT_n  = ~WT;

endmodule

// File: tb/tb_param_timer_gen.sv
module tb_param_timer_gen;

    localparam int M_WAIT = 0;
    localparam int M_LIVE = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

`ifdef TIMER_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic CLOCK;
    logic SIM_RST, VCC, GND, STOP, STEP;

    logic [31:0] o_phs  [3];
    logic [31:0] o_phsn [3];
    logic [31:0] o_t    [3];
    logic [4:0]  o_str  [3];
    logic        o_mct  [3];
    logic        o_ovf  [3];
    logic        o_halt [3];

    int p_div [3] = '{2, 1, 2};
    int p_nph [3] = '{4, 3, 4};
    int p_nt  [3] = '{12, 2, 12};
    int p_ct  [3] = '{2, 1, 2};
    int p_dly [3] = '{1, 1, 2};

    int m_mode  [3];
    int m_ticks [3];

    int checks = 0;
    int errors = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Instance 0: defaults; 1: minimal sweep; 2: defaults with OVF_DLY=2.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GDIV = (g == 1) ? 1 : 2;
        localparam int GNPH = (g == 1) ? 3 : 4;
        localparam int GNT  = (g == 1) ? 2 : 12;
        localparam int GCT  = (g == 1) ? 1 : 2;
        localparam int GDLY = (g == 2) ? 2 : 1;
        logic [GNPH-1:0] phs, phs_n;
        logic [GNT-1:0]  t;
        logic rt, wt, ct, ct_n, wt_n, mct, ovf_n, halted;

        param_timer_gen #(
            .DIV(GDIV), .NPHASE(GNPH), .NT(GNT), .RT_PH(0), .WT_PH(1),
            .CT_PH(GCT), .OVF_DLY(GDLY)
        ) dut (
            .CLOCK(CLOCK), .SIM_RST(SIM_RST), .VCC(VCC), .GND(GND),
            .STOP(STOP), .STEP(STEP), .PHS(phs), .PHS_n(phs_n),
            .RT(rt), .WT(wt), .CT(ct), .CT_n(ct_n), .WT_n(wt_n), .T(t),
            .MCT_END(mct), .OVFSTB_n(ovf_n), .HALTED(halted)
        );

        assign o_phs[g]  = 32'(phs);
        assign o_phsn[g] = 32'(phs_n);
        assign o_t[g]    = 32'(t);
        assign o_str[g]  = {rt, wt, ct, ct_n, wt_n};
        assign o_mct[g]  = mct;
        assign o_ovf[g]  = ovf_n;
        assign o_halt[g] = halted;
    end

    task automatic check(input int inst, input string name,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", name, inst, obs, exp);
        end
    endtask

    // Reference model: a count of displayed clocks since reset plus a mode.
    // Position and time pulse follow from plain division of that count.
    task automatic modelStep(input int i, input bit rst, input bit stop, input bit step);
        int per;
        per = p_div[i] * p_nph[i];
        if (!rst) begin
            m_mode[i]  = M_WAIT;
            m_ticks[i] = 0;
        end else begin
            case (m_mode[i])
                M_WAIT: m_mode[i] = M_LIVE;
                M_LIVE: begin
                    if ((m_ticks[i] % per) == per - 1 && stop) m_mode[i] = M_HALT;
                    m_ticks[i]++;
                end
                M_HALT: begin
                    if (!stop) m_mode[i] = M_WAIT;
                    else if (STEP_ON && step) m_mode[i] = M_STEP;
                end
                default: begin
                    if ((m_ticks[i] % per) == per - 1) begin
                        if (!stop) m_mode[i] = M_LIVE;
                        else if (!step) m_mode[i] = M_HALT;
                    end
                    m_ticks[i]++;
                end
            endcase
        end
    endtask

    task automatic checkOutput(input int i);
        int per, pos, ph, tp;
        bit live;
        logic [31:0] e_phs, e_t, mask;
        logic [4:0]  e_str;
        per   = p_div[i] * p_nph[i];
        live  = (m_mode[i] == M_LIVE) || (m_mode[i] == M_STEP);
        pos   = m_ticks[i] % per;
        ph    = pos / p_div[i];
        tp    = (m_ticks[i] / per) % p_nt[i];
        mask  = (32'd1 << p_nph[i]) - 32'd1;
        e_phs = live ? (32'd1 << ph) : 32'd0;
        e_t   = live ? (32'd1 << tp) : 32'd0;
        e_str[4] = live && (ph == 0);
        e_str[3] = live && (ph == 1);
        e_str[2] = live && (ph == p_ct[i]);
        e_str[1] = !e_str[2];
        e_str[0] = !e_str[3];
        check(i, "phs", o_phs[i], e_phs);
        check(i, "phs_n", o_phsn[i], ~e_phs & mask);
        check(i, "t", o_t[i], e_t);
        check(i, "strobes", 32'(o_str[i]), 32'(e_str));
        check(i, "mct_end", 32'(o_mct[i]),
              32'(live && (tp == p_nt[i] - 1) && (pos == per - 1)));
        check(i, "ovfstb_n", 32'(o_ovf[i]),
              32'(!(live && (pos == p_div[i] * (p_ct[i] + 1) + p_dly[i] - 1))));
        check(i, "halted", 32'(o_halt[i]), 32'(m_mode[i] == M_HALT));
    endtask

    // Drive inputs between edges, clock once, advance the model, then compare
    // every instance on the falling edge.
    task automatic applyStimulus(input bit rst, input bit stop, input bit step, input int n);
        for (int k = 0; k < n; k++) begin
            SIM_RST = rst;
            STOP    = stop;
            STEP    = step;
            @(posedge CLOCK);
            for (int i = 0; i < 3; i++) modelStep(i, rst, stop, step);
            @(negedge CLOCK);
            for (int i = 0; i < 3; i++) checkOutput(i);
        end
    endtask

    initial begin
        int active;
        int strobes;
        bit rnd_stop;
        SIM_RST = 1'b0;
        STOP    = 1'b0;
        STEP    = 1'b0;
        VCC     = 1'b1;
        GND     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_mode[i]  = M_WAIT;
            m_ticks[i] = 0;
        end
        $display("[TB] start");

        applyStimulus(1'b0, 1'b0, 1'b0, 3);

        // Free run from reset release; c counts edges after release.
        for (int c = 0; c < 100; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            if (c == 0) begin
                check(0, "c0_phs", o_phs[0], 32'h1);
                check(0, "c0_t", o_t[0], 32'h1);
                check(0, "c0_str", 32'(o_str[0]), 32'h13);
            end
            if (c == 2) check(0, "c2_str", 32'(o_str[0]), 32'h0a);
            if (c == 4) check(0, "c4_str", 32'(o_str[0]), 32'h05);
            if (c == 5) check(0, "c5_ovf", 32'(o_ovf[0]), 32'h1);
            if (c == 6) begin
                check(0, "c6_ovf", 32'(o_ovf[0]), 32'h0);
                check(2, "c6_ovf", 32'(o_ovf[2]), 32'h1);
            end
            if (c == 7) check(2, "c7_ovf", 32'(o_ovf[2]), 32'h0);
            if (c == 8) check(0, "c8_t", o_t[0], 32'h2);
            if (c == 2) check(1, "c2_ovf", 32'(o_ovf[1]), 32'h0);
            if (c == 5 || c == 11) check(1, "mct_sweep", 32'(o_mct[1]), 32'h1);
            if (c == 94) check(0, "c94_mct", 32'(o_mct[0]), 32'h0);
            if (c == 95) check(0, "c95_mct", 32'(o_mct[0]), 32'h1);
            if (c == 96) check(0, "c96_t", o_t[0], 32'h1);
        end

        // STOP held: instance 0 sits at position 3, halts at the boundary.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            if (k == 3) check(0, "pre_halt", 32'(o_halt[0]), 32'h0);
            if (k == 4) begin
                check(0, "halt_flag", 32'(o_halt[0]), 32'h1);
                check(0, "halt_phs", o_phs[0], 32'h0);
            end
        end

        // Single STEP pulse while halted.
        active  = 0;
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b1, (k == 0), 1);
            if (o_t[0] != 32'h0) active++;
            if (o_ovf[0] == 1'b0) strobes++;
        end
        check(0, "step_active", 32'(active), STEP_ON ? 32'd8 : 32'd0);
        check(0, "step_ovf", 32'(strobes), STEP_ON ? 32'd1 : 32'd0);
        check(0, "step_halted", 32'(o_halt[0]), 32'h1);

        // Release STOP: one blank edge, then position 0 of the held pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        check(0, "resume_phs", o_phs[0], 32'h1);

        // Reset mid time pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        check(0, "rst_phs", o_phs[0], 32'h0);
        check(0, "rst_phsn", o_phsn[0], 32'hf);
        check(0, "rst_ovf", 32'(o_ovf[0]), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        check(0, "rel_t", o_t[0], 32'h1);
        check(0, "rel_phs", o_phs[0], 32'h1);

        // Randomised STOP / STEP / reset traffic.
        rnd_stop = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) rnd_stop = !rnd_stop;
            applyStimulus(($urandom_range(0, 299) != 0), rnd_stop,
                          ($urandom_range(0, 3) == 0), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
